// File: rtl/blk_mem_dsp_unit.sv
`timescale 1ns/1ps
// Display data source: 4-word preset block RAM plus pipelined P = A*B + C.
// Optional BLK_MEM_WRITE_FIRST_EN selects write-first douta on writes (default read-first).
module blk_mem_dsp_unit #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned ADDR_W  = 2,
    parameter logic [DATA_W-1:0] INIT0 = DATA_W'(1234),
    parameter logic [DATA_W-1:0] INIT1 = DATA_W'(5678),
    parameter logic [DATA_W-1:0] INIT2 = DATA_W'(9012),
    parameter logic [DATA_W-1:0] INIT3 = DATA_W'(3456),
    parameter int unsigned DSP_LAT = 3
) (
    input  logic              clock_100Mhz,
    input  logic              reset,
    input  logic              ena,
    input  logic              wea,
    input  logic [ADDR_W-1:0] addra,
    input  logic [DATA_W-1:0] dina,
    output logic [DATA_W-1:0] douta,
    input  logic [6:0]        A,
    input  logic [7:0]        B,
    input  logic [6:0]        C,
    output logic [DATA_W-1:0] P
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    if (ADDR_W != 2) begin : g_bad_addr_w
        $error("blk_mem_dsp_unit: preset table covers exactly 4 words");
    end
    if (DSP_LAT < 1 || DSP_LAT > 4) begin : g_bad_lat
        $error("blk_mem_dsp_unit: DSP_LAT must be 1..4");
    end

    // Preset contents load at configuration only; reset never touches the array.
    logic [DATA_W-1:0] mem [DEPTH] = '{INIT0, INIT1, INIT2, INIT3};

    // Port A: a write landing on a reset edge is dropped, keeping the old word.
    always_ff @(posedge clock_100Mhz or posedge reset) begin
        if (reset) begin
            douta <= '0;
        end else if (ena) begin
            if (wea) begin
                mem[addra] <= dina;
`ifdef BLK_MEM_WRITE_FIRST_EN
                douta <= dina;
`else
                douta <= mem[addra];
`endif
            end else begin
                douta <= mem[addra];
            end
        end
    end

    logic [DATA_W-1:0] mac_c;
    logic [DATA_W-1:0] pipe [DSP_LAT];

    assign mac_c = DATA_W'(A) * DATA_W'(B) + DATA_W'(C);

    // Result shift pipeline; stage 0 captures the sample edge, last stage drives P.
    always_ff @(posedge clock_100Mhz or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DSP_LAT); i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= mac_c;
            for (int i = 1; i < int'(DSP_LAT); i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign P = pipe[DSP_LAT-1];

endmodule

// File: tb/tb_blk_mem_dsp_unit.sv
`timescale 1ns/1ps
// Scoreboard bench for blk_mem_dsp_unit: driver queues expected douta/P per cycle, monitor compares.
module tb_blk_mem_dsp_unit;

    localparam int unsigned LAT = 3;

    logic        clock_100Mhz = 1'b0;
    logic        reset = 1'b1;
    logic        ena = 1'b0;
    logic        wea = 1'b0;
    logic [1:0]  addra = '0;
    logic [15:0] dina = '0;
    logic [15:0] douta;
    logic [6:0]  A = 7'd0;
    logic [7:0]  B = 8'd1;
    logic [6:0]  C = 7'd1;
    logic [15:0] P;

    typedef struct {
        int          due;
        bit          is_p;
        logic [15:0] exp;
        int          tag;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   passes = 0;
    int   tag_n = 0;

    blk_mem_dsp_unit #(.DSP_LAT(LAT)) dut (
        .clock_100Mhz(clock_100Mhz),
        .reset(reset),
        .ena(ena),
        .wea(wea),
        .addra(addra),
        .dina(dina),
        .douta(douta),
        .A(A),
        .B(B),
        .C(C),
        .P(P)
    );

    always #5 clock_100Mhz = ~clock_100Mhz;

    always @(posedge clock_100Mhz) cyc = cyc + 1;

    task automatic push(input bit is_p, input int due, input logic [15:0] exp);
        exp_t e;
        e.due  = due;
        e.is_p = is_p;
        e.exp  = exp;
        e.tag  = tag_n;
        tag_n++;
        sb.push_back(e);
    endtask

    // Monitor: outputs are stable at the falling edge.
    always @(negedge clock_100Mhz) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due == cyc) begin
                logic [15:0] act;
                act = sb[i].is_p ? P : douta;
                checks++;
                if (act === sb[i].exp) passes++;
                else $display("FAIL %s #%0d cycle %0d: got %0d (0x%h), expected %0d (0x%h)",
                              sb[i].is_p ? "P" : "douta", sb[i].tag, cyc,
                              act, act, sb[i].exp, sb[i].exp);
                sb.delete(i);
            end
        end
    end

    // One directed vector: RAM response due next cycle, P due LAT cycles later.
    task automatic apply(input bit en, input bit we, input logic [1:0] ad,
                         input logic [15:0] di, input logic [6:0] a,
                         input logic [7:0] b, input logic [6:0] c,
                         input logic [15:0] exp_d, input logic [15:0] exp_p);
        @(negedge clock_100Mhz);
        ena = en; wea = we; addra = ad; dina = di;
        A = a; B = b; C = c;
        push(1'b0, cyc + 1, exp_d);
        push(1'b1, cyc + int'(LAT), exp_p);
    endtask

    // Immediate check: call mid high phase so the next monitor edge sees it with no clock between.
    task automatic check_now(input logic [15:0] exp_d, input logic [15:0] exp_p);
        push(1'b0, cyc, exp_d);
        push(1'b1, cyc, exp_p);
    endtask

    localparam logic [15:0] WR_DOUT =
`ifdef BLK_MEM_WRITE_FIRST_EN
        16'h00FF;
`else
        16'd9012;
`endif

    initial begin
        // Reset held with A=0,B=1,C=1 on the inputs: outputs must sit at zero.
        repeat (2) begin
            @(posedge clock_100Mhz); #2;
            check_now(16'd0, 16'd0);
            checks++;
            if (douta === 16'd0 && P === 16'd0) passes++;
            else $display("FAIL in reset: douta=%0d P=%0d, expected 0/0", douta, P);
        end
        @(negedge clock_100Mhz);
        reset = 1'b0;
        push(1'b0, cyc + 1, 16'd0);
        push(1'b1, cyc + 1, 16'd0);
        push(1'b1, cyc + 2, 16'd0);
        push(1'b1, cyc + 3, 16'd1);

        //     en  we  ad     din       A     B     C    douta      P
        apply(1, 0, 2'd0, 16'h0000,   0,    1,    1, 16'd1234,     1);
        apply(1, 0, 2'd1, 16'h0000,   0,    1,    1, 16'd5678,     1);
        apply(1, 0, 2'd2, 16'h0000,   0,    1,    1, 16'd9012,     1);
        apply(1, 0, 2'd3, 16'h0000, 127,  255,  127, 16'd3456, 32512);
        apply(1, 1, 2'd2, 16'h00FF,  10,   20,    5,  WR_DOUT,   205);
        apply(1, 0, 2'd2, 16'h0000,   3,    4,    5, 16'h00FF,    17);
        apply(0, 1, 2'd2, 16'hBEEF, 100,  200,   50, 16'h00FF, 20050);
        apply(0, 0, 2'd0, 16'h1111,   1,    1,    0, 16'h00FF,     1);
        apply(0, 1, 2'd0, 16'h2222,   2,    3,    4, 16'h00FF,    10);
        apply(1, 0, 2'd2, 16'h0000,   0,    0,    0, 16'h00FF,     0);
        apply(1, 0, 2'd0, 16'h0000,   7,    8,    9, 16'd1234,    65);
        apply(1, 0, 2'd3, 16'h0000,  50,   50,   50, 16'd3456,  2550);

        // Fill the pipeline with 9*9+9 and hold, then reset mid-stream with a write pending.
        @(negedge clock_100Mhz);
        ena = 1'b0; A = 7'd9; B = 8'd9; C = 7'd9;
        push(1'b1, cyc + int'(LAT), 16'd90);
        push(1'b0, cyc + int'(LAT), 16'd3456);
        repeat (int'(LAT)) @(negedge clock_100Mhz);
        @(posedge clock_100Mhz); #2;
        ena = 1'b1; wea = 1'b1; addra = 2'd1; dina = 16'hDEAD;
        #1 reset = 1'b1;
        check_now(16'd0, 16'd0);
        #1;
        checks++;
        if (P === 16'd0 && douta === 16'd0) passes++;
        else $display("FAIL async reset: douta=%0d P=%0d, expected 0/0", douta, P);
        repeat (2) @(negedge clock_100Mhz);
        reset = 1'b0;
        wea = 1'b0;
        push(1'b0, cyc + 1, 16'd5678);
        push(1'b1, cyc + 1, 16'd0);
        push(1'b1, cyc + 2, 16'd0);
        push(1'b1, cyc + 3, 16'd90);
        @(negedge clock_100Mhz);
        ena = 1'b0;

        // Drain the scoreboard within a fixed budget; anything left is a miss.
        for (int k = 0; k < 20 && sb.size() > 0; k++) @(negedge clock_100Mhz);
        #1;
        while (sb.size() > 0) begin
            checks++;
            $display("FAIL %s #%0d never observed: due cycle %0d, expected %0d, now cycle %0d",
                     sb[0].is_p ? "P" : "douta", sb[0].tag, sb[0].due, sb[0].exp, cyc);
            sb.delete(0);
        end
        $display("%0d/%0d checks passed", passes, checks);
        if (passes == checks) $display("TEST PASSED");
        else $display("TEST FAILED");
        $finish;
    end

endmodule
